scrambler_tx: RTL and testbench



---
 rtl/scrambler_tx.sv | 75 +++++++
 tb/tb_scrambler_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scrambler_tx.sv
// 64b/66b self-synchronous payload scrambler (1 + x^39 + x^58), one registered cycle of latency.
// No backpressure: every enabled valid block is accepted; i_enable=0 freezes all state.
module scrambler_tx #(
  parameter int                  NB_DATA    = 66,
  parameter int                  NB_STATE   = 58,
  parameter logic [NB_STATE-1:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF,
  parameter int                  NB_ERR_CNT = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic [NB_DATA-1:0]    i_data,
  input  logic                  i_aligner_tag,
  input  logic                  i_bypass,
  input  logic                  i_seed_load,
  input  logic [NB_STATE-1:0]   i_seed,
  output logic [NB_DATA-1:0]    o_data,
  output logic                  o_valid,
  output logic                  o_aligner_tag,
  output logic                  o_header_error,
  output logic [NB_ERR_CNT-1:0] o_header_err_count
);

  localparam int NB_PAYLOAD = NB_DATA - 2;

  logic [NB_STATE-1:0]   state;
  logic [NB_STATE-1:0]   st_walk;
  logic [NB_PAYLOAD-1:0] scr_payload;
  logic                  fb_bit;
  logic                  scr_active;
  logic                  hdr_bad;

  // Bit-serial recurrence unrolled MSB first; st_walk[0] always holds the newest scrambled bit.
  always_comb begin
    st_walk     = state;
    scr_payload = '0;
    fb_bit      = 1'b0;
    for (int k = NB_PAYLOAD - 1; k >= 0; k--) begin
      fb_bit         = i_data[k] ^ st_walk[38] ^ st_walk[57];
      scr_payload[k] = fb_bit;
      st_walk        = {st_walk[NB_STATE-2:0], fb_bit};
    end
  end

  assign scr_active = i_valid && !i_aligner_tag && !i_bypass;
  assign hdr_bad    = (i_data[NB_DATA-1:NB_DATA-2] == 2'b00) ||
                      (i_data[NB_DATA-1:NB_DATA-2] == 2'b11);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state              <= SEED;
      o_data             <= '0;
      o_valid            <= 1'b0;
      o_aligner_tag      <= 1'b0;
      o_header_error     <= 1'b0;
      o_header_err_count <= '0;
    end else if (i_enable) begin
      o_valid        <= i_valid;
      o_header_error <= i_valid && hdr_bad;
      if (i_valid) begin
        o_aligner_tag <= i_aligner_tag;
        o_data        <= scr_active ? {i_data[NB_DATA-1:NB_DATA-2], scr_payload} : i_data;
        if (hdr_bad && (o_header_err_count != '1))
          o_header_err_count <= o_header_err_count + 1'b1;
      end
      // A seed load wins over the block's post-scramble state, which is discarded.
      if (i_seed_load)
        state <= i_seed;
      else if (scr_active)
        state <= st_walk;
    end
  end

endmodule

// File: tb/tb_scrambler_tx.sv
// Bench for scrambler_tx: hand-computed vector table, directed corner sequences and a
// randomized run against a bit-stream reference model (s_n = d_n ^ s_{n-39} ^ s_{n-58}).
module tb_scrambler_tx;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_valid;
  logic [65:0] i_data;
  logic        i_aligner_tag;
  logic        i_bypass;
  logic        i_seed_load;
  logic [57:0] i_seed;
  logic [65:0] o_data;
  logic        o_valid;
  logic        o_aligner_tag;
  logic        o_header_error;
  logic [15:0] o_header_err_count;

  scrambler_tx dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_data(i_data), .i_aligner_tag(i_aligner_tag), .i_bypass(i_bypass),
    .i_seed_load(i_seed_load), .i_seed(i_seed), .o_data(o_data), .o_valid(o_valid),
    .o_aligner_tag(o_aligner_tag), .o_header_error(o_header_error),
    .o_header_err_count(o_header_err_count)
  );

  always #5 i_clock = ~i_clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: history of scrambled bits, hist[0] = most recent.
  bit          hist[$];
  bit          dh[$];
  logic [65:0] e_data;
  logic        e_valid, e_tag, e_herr;
  int          e_cnt;
  bit          e_scr;

  function automatic void model_seed(input logic [57:0] sd);
    hist.delete();
    for (int j = 0; j < 58; j++) hist.push_back(sd[j]);
  endfunction

  function automatic logic [63:0] model_scramble(input logic [63:0] p, input bit commit);
    bit h[$];
    logic [63:0] r;
    h = hist;
    for (int k = 63; k >= 0; k--) begin
      bit s;
      s = p[k] ^ h[38] ^ h[57];
      r[k] = s;
      h.push_front(s);
      void'(h.pop_back());
    end
    if (commit) hist = h;
    return r;
  endfunction

  function automatic logic [63:0] descramble(input logic [63:0] s);
    logic [63:0] r;
    for (int k = 63; k >= 0; k--) begin
      r[k] = s[k] ^ dh[38] ^ dh[57];
      dh.push_front(s[k]);
      void'(dh.pop_back());
    end
    return r;
  endfunction

  function automatic void model_reset();
    model_seed(SEED);
    e_data = '0; e_valid = 0; e_tag = 0; e_herr = 0; e_cnt = 0; e_scr = 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".data"},  o_data, e_data);
    chk({tag, ".valid"}, 66'(o_valid), 66'(e_valid));
    chk({tag, ".tag"},   66'(o_aligner_tag), 66'(e_tag));
    chk({tag, ".herr"},  66'(o_header_error), 66'(e_herr));
    chk({tag, ".cnt"},   66'(o_header_err_count), 66'(e_cnt));
  endtask

  // Advance the model with the current inputs, clock once, sample 1 ns after the edge.
  task automatic step(input bit do_check, input string tag);
    logic hdr_bad;
    hdr_bad = (i_data[65:64] == 2'b00) || (i_data[65:64] == 2'b11);
    if (i_enable) begin
      e_valid = i_valid;
      e_herr  = i_valid && hdr_bad;
      if (i_valid) begin
        e_tag = i_aligner_tag;
        e_scr = !i_aligner_tag && !i_bypass;
        if (hdr_bad && e_cnt < 65535) e_cnt++;
        e_data = e_scr ? {i_data[65:64], model_scramble(i_data[63:0], !i_seed_load)} : i_data;
      end else begin
        e_scr = 0;
      end
      if (i_seed_load) model_seed(i_seed);
    end
    @(posedge i_clock);
    #1;
    if (do_check) check_all(tag);
  endtask

  task automatic blk(input logic [65:0] d, input logic tag, input logic byp);
    i_valid = 1; i_data = d; i_aligner_tag = tag; i_bypass = byp; i_seed_load = 0;
  endtask

  task automatic idle();
    i_valid = 0; i_aligner_tag = 0; i_bypass = 0; i_seed_load = 0;
  endtask

  task automatic load_seed(input logic [57:0] sd);
    idle(); i_seed_load = 1; i_seed = sd;
    step(1, "seed");
    i_seed_load = 0;
  endtask

  task automatic do_reset();
    i_reset = 0;
    model_reset();
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1;
  endtask

  function automatic logic [65:0] rnd_blk(input logic [1:0] hdr);
    return {hdr, $urandom, $urandom};
  endfunction

  typedef struct {
    logic [57:0] seed;
    logic [65:0] data;
    logic        tag;
    logic        byp;
    logic [65:0] exp;
    logic        herr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [65:0] a_blk, b_blk, exp_b, sent;
    logic [63:0] pay[6];
    bit          saved[$];
    int          pulses;

    tbl[0] = '{58'h0, {2'b01, 64'h8000_0000_0000_0000}, 0, 0, {2'b01, 64'h8000_0000_0100_0020}, 0};
    tbl[1] = '{58'h0, {2'b10, 64'h0},                   0, 0, {2'b10, 64'h0},                   0};
    tbl[2] = '{58'h0, {2'b01, 64'h1},                   0, 0, {2'b01, 64'h1},                   0};
    tbl[3] = '{58'h0, {2'b01, 64'h8000_0000_0100_0000}, 0, 0, {2'b01, 64'h8000_0000_0000_0020}, 0};
    tbl[4] = '{58'h0, 66'h1_e0_00_00_00_00_00_00_00,    1, 0, 66'h1_e0_00_00_00_00_00_00_00,    0};
    tbl[5] = '{58'h0, {2'b01, 64'hDEAD_BEEF_0123_4567}, 0, 1, {2'b01, 64'hDEAD_BEEF_0123_4567}, 0};
    tbl[6] = '{58'h0, {2'b11, 64'h0},                   0, 0, {2'b11, 64'h0},                   1};
    tbl[7] = '{58'h0, {2'b00, 64'h5},                   1, 0, {2'b00, 64'h5},                   1};

    // Reset hold and release with idle input.
    i_reset = 0; i_enable = 0; i_valid = 0; i_data = '0; i_aligner_tag = 0;
    i_bypass = 0; i_seed_load = 0; i_seed = '0;
    model_reset();
    #1;
    check_all("rst_async");
    repeat (3) @(posedge i_clock);
    #1;
    check_all("rst_hold");
    i_reset = 1; i_enable = 1;
    repeat (3) step(1, "rst_idle");
    blk(rnd_blk(2'b01), 0, 0);
    step(1, "first_blk_seed");

    // Hand-computed vectors.
    foreach (tbl[i]) begin
      load_seed(tbl[i].seed);
      blk(tbl[i].data, tbl[i].tag, tbl[i].byp);
      step(1, "tbl_model");
      chk($sformatf("tbl%0d.data", i), o_data, tbl[i].exp);
      chk($sformatf("tbl%0d.herr", i), 66'(o_header_error), 66'(tbl[i].herr));
      chk($sformatf("tbl%0d.tag", i), 66'(o_aligner_tag), 66'(tbl[i].tag));
    end

    // Tagged idle between A and B must not disturb B's scrambling.
    a_blk = rnd_blk(2'b01); b_blk = rnd_blk(2'b10);
    saved = hist;
    model_seed('0);
    void'(model_scramble(a_blk[63:0], 1));
    exp_b = {b_blk[65:64], model_scramble(b_blk[63:0], 1)};
    hist = saved;
    load_seed('0);
    blk(a_blk, 0, 0);                          step(1, "am_a");
    blk(66'h1_e0_00_00_00_00_00_00_00, 1, 0);  step(1, "am_idle");
    chk("am_idle_verbatim", o_data, 66'h1_e0_00_00_00_00_00_00_00);
    chk("am_idle_tag", 66'(o_aligner_tag), 66'd1);
    blk(b_blk, 0, 0);                          step(1, "am_b");
    chk("am_b_vs_ab", o_data, exp_b);

    // Header errors and counter saturation.
    do_reset();
    pulses = 0;
    foreach (tbl[i]) begin end
    for (int i = 0; i < 5; i++) begin
      blk(rnd_blk(i < 3 ? 2'b11 : (i == 3 ? 2'b00 : 2'b10)), 0, 0);
      step(1, "hdr");
      if (o_header_error) pulses++;
    end
    idle(); step(1, "hdr_idle");
    if (o_header_error) pulses++;
    chk("hdr_pulses", 66'(pulses), 66'd4);
    chk("hdr_count", 66'(o_header_err_count), 66'd4);
    for (int i = 0; i < 65538; i++) begin
      blk(rnd_blk(i[0] ? 2'b00 : 2'b11), 0, 0);
      step(0, "sat");
    end
    check_all("sat");
    chk("sat_ffff", 66'(o_header_err_count), 66'hFFFF);

    // Valid-low stall mid-stream.
    blk(rnd_blk(2'b01), 0, 0); step(1, "stall_pre");
    for (int i = 0; i < 5; i++) begin
      idle(); i_data = rnd_blk(2'b10); step(1, "stall_vld");
    end
    blk(rnd_blk(2'b01), 0, 0); step(1, "stall_post");

    // Enable low freezes everything, including a requested seed load.
    blk(rnd_blk(2'b10), 0, 0); step(1, "en_pre");
    i_enable = 0;
    for (int i = 0; i < 3; i++) begin
      blk(rnd_blk(2'b11), 0, 0); i_seed_load = 1; i_seed = 58'h1234;
      step(1, "en_low");
    end
    i_enable = 1;
    blk(rnd_blk(2'b01), 0, 0); step(1, "en_post");

    // Bypass passes blocks verbatim, then scrambling resumes from the frozen state.
    for (int i = 0; i < 4; i++) begin
      sent = rnd_blk(2'($urandom));
      blk(sent, 0, 1); step(1, "byp");
      chk("byp_verbatim", o_data, sent);
    end
    blk(rnd_blk(2'b01), 0, 0); step(1, "byp_resume");

    // Seed load colliding with an accepted block.
    blk(rnd_blk(2'b01), 0, 0); i_seed_load = 1; i_seed = {26'($urandom), $urandom};
    step(1, "sl_same");
    blk(rnd_blk(2'b10), 0, 0); step(1, "sl_next");

    // Descrambler recovers payload after the first 58 bits, whatever the seed.
    load_seed({26'($urandom), $urandom});
    dh.delete();
    for (int j = 0; j < 58; j++) dh.push_back(1'b0);
    for (int i = 0; i < 6; i++) begin
      sent = rnd_blk(2'b01);
      pay[i] = sent[63:0];
      blk(sent, 0, 0); step(1, "desc");
      if (i > 0) chk($sformatf("desc%0d", i), 66'(descramble(o_data[63:0])), 66'(pay[i]));
      else void'(descramble(o_data[63:0]));
    end

    // Asynchronous reset mid-burst.
    blk(rnd_blk(2'b01), 0, 0); step(1, "ar_pre");
    chk("ar_pre_valid", 66'(o_valid), 66'd1);
    #2 i_reset = 0;
    model_reset();
    #1;
    check_all("ar_async");
    #2 i_reset = 1;
    blk(rnd_blk(2'b10), 0, 0); step(1, "ar_post");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      i_enable      = ($urandom_range(0, 9) != 0);
      i_valid       = ($urandom_range(0, 9) < 7);
      i_aligner_tag = ($urandom_range(0, 9) == 0);
      i_bypass      = ($urandom_range(0, 9) == 0);
      i_seed_load   = ($urandom_range(0, 19) == 0);
      i_seed        = {26'($urandom), $urandom};
      i_data        = rnd_blk(2'($urandom));
      step(1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
